// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit and its scoreboard.
package hazard_pkg;

  // Widest register index a scoreboard entry can hold; narrower indices are zero-extended.
  localparam int SB_DEST_W = 8;

  // Scoreboard slot positions inside the per-source match vectors.
  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  // ALU operand source selects for the instruction in EX.
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_IDEX  = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                 valid;
    logic [SB_DEST_W-1:0] dest;
    logic                 reg_write;
    logic                 is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // A producer matches a source when it really writes that register and the
  // consumer really reads it; register 0 is hard-wired and never matches.
  function automatic logic entry_matches(input sb_entry_t            e,
                                         input logic [SB_DEST_W-1:0] src,
                                         input logic                 uses);
    return uses & e.valid & e.reg_write & (e.dest != '0) & (e.dest == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_unit_scoreboard.sv
// Three-slot shift register (EX, MEM, WB) of in-flight destinations, with
// squash of the EX slot and per-slot match flags for both ID sources.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  sb_entry_t             issue_entry,
  input  logic                  squash_ex,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  uses_rs,
  input  logic                  uses_rt,
  output logic                  ex_is_load,
  output logic [2:0]            match_rs,
  output logic [2:0]            match_rt
);

  sb_entry_t ex_entry;
  sb_entry_t mem_entry;
  sb_entry_t wb_entry;

  logic [SB_DEST_W-1:0] rs_ext;
  logic [SB_DEST_W-1:0] rt_ext;

  assign rs_ext     = SB_DEST_W'(rs);
  assign rt_ext     = SB_DEST_W'(rt);
  assign ex_is_load = ex_entry.valid & ex_entry.is_load;

  // Advance every slot one stage per cycle; a squashed EX slot never reaches MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_entry  <= SB_BUBBLE;
      mem_entry <= SB_BUBBLE;
      wb_entry  <= SB_BUBBLE;
    end else begin
      ex_entry  <= issue_entry;
      mem_entry <= squash_ex ? SB_BUBBLE : ex_entry;
      wb_entry  <= mem_entry;
    end
  end

  // Compare both ID sources against every in-flight producer.
  always_comb begin
    match_rs           = '0;
    match_rt           = '0;
    match_rs[SLOT_EX]  = entry_matches(ex_entry,  rs_ext, uses_rs);
    match_rs[SLOT_MEM] = entry_matches(mem_entry, rs_ext, uses_rs);
    match_rs[SLOT_WB]  = entry_matches(wb_entry,  rs_ext, uses_rs);
    match_rt[SLOT_EX]  = entry_matches(ex_entry,  rt_ext, uses_rt);
    match_rt[SLOT_MEM] = entry_matches(mem_entry, rt_ext, uses_rt);
    match_rt[SLOT_WB]  = entry_matches(wb_entry,  rt_ext, uses_rt);
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard detection, operand forwarding and redirect flush control for the
// five-stage MIPS pipeline. Stall and flush controls are combinational;
// forward selects are registered as the instruction enters EX.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int FWD_EN         = 1,
  parameter int RF_BYPASS      = 1,
  parameter int REDIRECT_STAGE = 2,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  redirect,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // Resolving in MEM means the instruction behind the redirect is already in
  // EX and must be dropped; resolving in EX only kills what is in IF and ID.
  localparam logic KILL_EX = (REDIRECT_STAGE == 2);

  sb_entry_t  issue_entry;
  logic       ex_is_load;
  logic [2:0] match_rs;
  logic [2:0] match_rt;
  logic       load_use;
  logic       wb_hit;
  logic       hazard;
  logic       stall;
  logic       issue;

  hazard_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_entry (issue_entry),
    .squash_ex   (redirect & KILL_EX),
    .rs          (id_rs),
    .rt          (id_rt),
    .uses_rs     (id_uses_rs),
    .uses_rt     (id_uses_rt),
    .ex_is_load  (ex_is_load),
    .match_rs    (match_rs),
    .match_rt    (match_rt)
  );

  // Youngest matching producer decides where the operand comes from.
  function automatic fwd_sel_t pick_fwd(input logic [2:0] m);
    if (m[SLOT_EX])  return FWD_EXMEM;
    if (m[SLOT_MEM]) return FWD_MEMWB;
    return FWD_IDEX;
  endfunction

  // Decide whether the ID instruction must wait, and whether it issues this cycle.
  always_comb begin
    load_use = ex_is_load & (match_rs[SLOT_EX] | match_rt[SLOT_EX]);
    wb_hit   = (RF_BYPASS == 0) & (match_rs[SLOT_WB] | match_rt[SLOT_WB]);
    if (FWD_EN != 0) begin
      hazard = load_use | wb_hit;
    end else begin
      hazard = match_rs[SLOT_EX] | match_rs[SLOT_MEM] |
               match_rt[SLOT_EX] | match_rt[SLOT_MEM] | wb_hit;
    end
    stall = id_valid & hazard & ~redirect;
    issue = id_valid & ~stall & ~redirect;
  end

  // Build the scoreboard entry for the instruction entering EX, or a bubble.
  always_comb begin
    issue_entry = SB_BUBBLE;
    if (issue) begin
      issue_entry.valid     = 1'b1;
      issue_entry.dest      = SB_DEST_W'(id_dest);
      issue_entry.reg_write = id_reg_write;
      issue_entry.is_load   = id_mem_read;
    end
  end

  assign pc_en        = ~stall;
  assign if_id_en     = ~stall;
  assign if_id_flush  = redirect;
  assign id_ex_flush  = redirect | stall;
  assign ex_mem_flush = redirect & KILL_EX;

  // Capture the operand sources for the instruction entering EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a_sel <= FWD_IDEX;
      fwd_b_sel <= FWD_IDEX;
    end else if (issue && (FWD_EN != 0)) begin
      fwd_a_sel <= pick_fwd(match_rs);
      fwd_b_sel <= pick_fwd(match_rt);
    end else begin
      fwd_a_sel <= FWD_IDEX;
      fwd_b_sel <= FWD_IDEX;
    end
  end

  // Saturating counts of stall cycles and redirect cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Testbench for pipeline_hazard_unit: directed vector table, a short
// no-forwarding sequence and a randomized run against a reference model.
module tb_pipeline_hazard_unit;

  localparam int NDUT = 3;

  // Instance configurations: 0 = forwarding, bypass, redirect in MEM
  //                          1 = no forwarding, bypass, redirect in EX
  //                          2 = forwarding, no bypass, redirect in EX
  function automatic bit cfg_fwd(int c);
    return (c != 1);
  endfunction
  function automatic bit cfg_byp(int c);
    return (c != 2);
  endfunction
  function automatic int cfg_stage(int c);
    return (c == 0) ? 2 : 1;
  endfunction

  localparam bit [8:0] C_NORM  = 9'b1_1_0_0_0_00_00;
  localparam bit [8:0] C_STALL = 9'b0_0_0_1_0_00_00;
  localparam bit [8:0] C_REDIR = 9'b1_1_1_1_1_00_00;
  localparam bit [8:0] C_LU    = 9'b1_1_0_0_0_10_10;
  localparam bit [8:0] C_A01   = 9'b1_1_0_0_0_01_00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, redirect;
  logic [4:0] id_rs, id_rt, id_dest;

  logic        pc_en[NDUT], if_id_en[NDUT], if_id_flush[NDUT], id_ex_flush[NDUT], ex_mem_flush[NDUT];
  logic [1:0]  fwd_a_sel[NDUT], fwd_b_sel[NDUT];
  logic [15:0] stall_cnt[NDUT], flush_cnt[NDUT];

  pipeline_hazard_unit #(
    .REG_ADDR_W(5), .FWD_EN(1), .RF_BYPASS(1), .REDIRECT_STAGE(2), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .redirect(redirect),
    .pc_en(pc_en[0]), .if_id_en(if_id_en[0]), .if_id_flush(if_id_flush[0]),
    .id_ex_flush(id_ex_flush[0]), .ex_mem_flush(ex_mem_flush[0]),
    .fwd_a_sel(fwd_a_sel[0]), .fwd_b_sel(fwd_b_sel[0]),
    .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
  );

  pipeline_hazard_unit #(
    .REG_ADDR_W(5), .FWD_EN(0), .RF_BYPASS(1), .REDIRECT_STAGE(1), .CNT_W(16)
  ) dut_nf (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .redirect(redirect),
    .pc_en(pc_en[1]), .if_id_en(if_id_en[1]), .if_id_flush(if_id_flush[1]),
    .id_ex_flush(id_ex_flush[1]), .ex_mem_flush(ex_mem_flush[1]),
    .fwd_a_sel(fwd_a_sel[1]), .fwd_b_sel(fwd_b_sel[1]),
    .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
  );

  pipeline_hazard_unit #(
    .REG_ADDR_W(5), .FWD_EN(1), .RF_BYPASS(0), .REDIRECT_STAGE(1), .CNT_W(16)
  ) dut_nb (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .redirect(redirect),
    .pc_en(pc_en[2]), .if_id_en(if_id_en[2]), .if_id_flush(if_id_flush[2]),
    .id_ex_flush(id_ex_flush[2]), .ex_mem_flush(ex_mem_flush[2]),
    .fwd_a_sel(fwd_a_sel[2]), .fwd_b_sel(fwd_b_sel[2]),
    .stall_cnt(stall_cnt[2]), .flush_cnt(flush_cnt[2])
  );

  typedef struct {
    bit       rst;
    bit       v;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       urs;
    bit       urt;
    bit [4:0] dest;
    bit       rw;
    bit       ld;
    bit       redir;
  } stim_t;

  typedef struct {
    string    name;
    stim_t    in;
    bit [8:0] ctl;
    int       stalls;
    int       flushes;
  } vec_t;

  // An instruction sitting in the pipeline, indexed by how many cycles ago it issued.
  typedef struct {
    bit       valid;
    bit [4:0] dest;
    bit       rw;
    bit       ld;
  } slot_t;

  int    checks;
  int    errors;
  stim_t cur;
  vec_t  vecs[$];
  slot_t hist[NDUT][1:3];
  bit [1:0] m_fa[NDUT];
  bit [1:0] m_fb[NDUT];
  int    m_stall[NDUT];
  int    m_flush[NDUT];

  function automatic stim_t st(bit rst, bit v, int rs, int rt, bit urs, bit urt,
                               int dest, bit rw, bit ld, bit redir);
    stim_t s;
    s.rst = rst; s.v = v; s.rs = 5'(rs); s.rt = 5'(rt); s.urs = urs; s.urt = urt;
    s.dest = 5'(dest); s.rw = rw; s.ld = ld; s.redir = redir;
    return s;
  endfunction

  function automatic stim_t nop();
    return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t vec(string name, stim_t s, bit [8:0] ctl, int stalls, int flushes);
    vec_t r;
    r.name = name; r.in = s; r.ctl = ctl; r.stalls = stalls; r.flushes = flushes;
    return r;
  endfunction

  function automatic logic [8:0] ctl_of(int c);
    return {pc_en[c], if_id_en[c], if_id_flush[c], id_ex_flush[c], ex_mem_flush[c],
            fwd_a_sel[c], fwd_b_sel[c]};
  endfunction

  task automatic apply_stimulus(input stim_t s);
    cur          = s;
    reset        = s.rst;
    id_valid     = s.v;
    id_rs        = s.rs;
    id_rt        = s.rt;
    id_uses_rs   = s.urs;
    id_uses_rt   = s.urt;
    id_dest      = s.dest;
    id_reg_write = s.rw;
    id_mem_read  = s.ld;
    redirect     = s.redir;
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a producer that issued `age` cycles ago blocks the ID
  // instruction if its value cannot yet reach EX by any available path.
  function automatic bit dep(slot_t s, bit [4:0] src, bit uses);
    return uses && s.valid && s.rw && (s.dest != 0) && (s.dest == src);
  endfunction

  function automatic bit too_early(int c, int age, bit is_load);
    if (age == 3) return !cfg_byp(c);
    if (!cfg_fwd(c)) return 1'b1;
    return (age == 1) && is_load;
  endfunction

  function automatic bit model_stall(int c);
    bit blk;
    blk = 1'b0;
    for (int a = 1; a <= 3; a++) begin
      if ((dep(hist[c][a], cur.rs, cur.urs) || dep(hist[c][a], cur.rt, cur.urt)) &&
          too_early(c, a, hist[c][a].ld))
        blk = 1'b1;
    end
    return cur.v && !cur.redir && blk;
  endfunction

  function automatic bit [1:0] model_fwd(int c, bit [4:0] src, bit uses);
    for (int a = 1; a <= 2; a++) begin
      if (dep(hist[c][a], src, uses)) return (a == 1) ? 2'b01 : 2'b10;
    end
    return 2'b00;
  endfunction

  task automatic model_check(input int c, input int cyc);
    bit s;
    bit [8:0] exp;
    s   = model_stall(c);
    exp = {~s, ~s, cur.redir, cur.redir | s, cur.redir && (cfg_stage(c) == 2), m_fa[c], m_fb[c]};
    check_output($sformatf("rand dut%0d cyc%0d ctl", c, cyc), 32'(ctl_of(c)), 32'(exp));
    check_output($sformatf("rand dut%0d cyc%0d stall_cnt", c, cyc), 32'(stall_cnt[c]), 32'(m_stall[c]));
    check_output($sformatf("rand dut%0d cyc%0d flush_cnt", c, cyc), 32'(flush_cnt[c]), 32'(m_flush[c]));
  endtask

  task automatic model_step(input int c);
    slot_t e;
    slot_t n;
    bit    s;
    bit    iss;
    e = '{valid: 1'b0, dest: 5'd0, rw: 1'b0, ld: 1'b0};
    if (cur.rst) begin
      for (int a = 1; a <= 3; a++) hist[c][a] = e;
      m_fa[c] = 2'b00; m_fb[c] = 2'b00; m_stall[c] = 0; m_flush[c] = 0;
    end else begin
      s   = model_stall(c);
      iss = cur.v && !s && !cur.redir;
      m_fa[c] = (iss && cfg_fwd(c)) ? model_fwd(c, cur.rs, cur.urs) : 2'b00;
      m_fb[c] = (iss && cfg_fwd(c)) ? model_fwd(c, cur.rt, cur.urt) : 2'b00;
      if (s && m_stall[c] < 65535) m_stall[c]++;
      if (cur.redir && m_flush[c] < 65535) m_flush[c]++;
      n = '{valid: 1'b1, dest: cur.dest, rw: cur.rw, ld: cur.ld};
      hist[c][3] = hist[c][2];
      hist[c][2] = (cur.redir && cfg_stage(c) == 2) ? e : hist[c][1];
      hist[c][1] = iss ? n : e;
    end
  endtask

  initial begin
    stim_t lw_t0, add_t1, nf_seq[5];
    bit    nf_pc[5];
    checks = 0;
    errors = 0;

    lw_t0  = st(0, 1, 29, 0, 1, 0, 8, 1, 1, 0);
    add_t1 = st(0, 1, 8, 8, 1, 1, 9, 1, 0, 0);

    vecs.push_back(vec("reset state",          nop(), C_NORM, 0, 0));
    vecs.push_back(vec("lw t0 issue",          lw_t0, C_NORM, 0, 0));
    vecs.push_back(vec("load-use stall",       add_t1, C_STALL, 0, 0));
    vecs.push_back(vec("add issues",           add_t1, C_NORM, 1, 0));
    vecs.push_back(vec("add in EX sel 10/10",  nop(), C_LU, 1, 0));
    vecs.push_back(vec("add t0",               st(0, 1, 11, 12, 1, 1, 8, 1, 0, 0), C_NORM, 1, 0));
    vecs.push_back(vec("sub t2 t0 t1",         st(0, 1, 8, 9, 1, 1, 10, 1, 0, 0), C_NORM, 1, 0));
    vecs.push_back(vec("sub in EX sel 01/00",  nop(), C_A01, 1, 0));
    vecs.push_back(vec("writer1 t0",           st(0, 1, 11, 0, 1, 0, 8, 1, 0, 0), C_NORM, 1, 0));
    vecs.push_back(vec("writer2 t0",           st(0, 1, 12, 0, 1, 0, 8, 1, 0, 0), C_NORM, 1, 0));
    vecs.push_back(vec("reader t0",            st(0, 1, 8, 13, 1, 1, 14, 1, 0, 0), C_NORM, 1, 0));
    vecs.push_back(vec("youngest wins",        nop(), C_A01, 1, 0));
    vecs.push_back(vec("addi zero",            st(0, 1, 11, 0, 1, 0, 0, 1, 0, 0), C_NORM, 1, 0));
    vecs.push_back(vec("read zero",            st(0, 1, 0, 0, 1, 1, 15, 1, 0, 0), C_NORM, 1, 0));
    vecs.push_back(vec("zero sel 00",          nop(), C_NORM, 1, 0));
    vecs.push_back(vec("lw t0 again",          lw_t0, C_NORM, 1, 0));
    vecs.push_back(vec("redirect over stall",  st(0, 1, 8, 8, 1, 1, 9, 1, 0, 1), C_REDIR, 1, 0));
    vecs.push_back(vec("counters after redir", st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_NORM, 1, 1));
    vecs.push_back(vec("after reset",          nop(), C_NORM, 0, 0));
    vecs.push_back(vec("lw before reset",      lw_t0, C_NORM, 0, 0));
    vecs.push_back(vec("stall under reset",    st(1, 1, 8, 8, 1, 1, 9, 1, 0, 0), C_STALL, 0, 0));
    vecs.push_back(vec("no carried hazard",    add_t1, C_NORM, 0, 0));
    vecs.push_back(vec("sel after reset",      nop(), C_NORM, 0, 0));

    apply_stimulus(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].in);
      #4;
      check_output({vecs[i].name, " ctl"}, 32'(ctl_of(0)), 32'(vecs[i].ctl));
      check_output({vecs[i].name, " stall_cnt"}, 32'(stall_cnt[0]), 32'(vecs[i].stalls));
      check_output({vecs[i].name, " flush_cnt"}, 32'(flush_cnt[0]), 32'(vecs[i].flushes));
      next_cycle();
    end

    // No forwarding: add t0 then sub t2,t0,t1 waits two cycles for the write-back.
    apply_stimulus(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    nf_seq[0] = st(0, 1, 11, 12, 1, 1, 8, 1, 0, 0);
    nf_seq[1] = st(0, 1, 8, 9, 1, 1, 10, 1, 0, 0);
    nf_seq[2] = nf_seq[1];
    nf_seq[3] = nf_seq[1];
    nf_seq[4] = nop();
    nf_pc     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(nf_seq[i]);
      #4;
      check_output($sformatf("nofwd pc_en step%0d", i), 32'(pc_en[1]), 32'(nf_pc[i]));
      if (i == 4) begin
        check_output("nofwd fwd_a_sel", 32'(fwd_a_sel[1]), 32'd0);
        check_output("nofwd fwd_b_sel", 32'(fwd_b_sel[1]), 32'd0);
        check_output("nofwd stall_cnt", 32'(stall_cnt[1]), 32'd2);
      end
      next_cycle();
    end

    // Randomized run of all three configurations against the model.
    apply_stimulus(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < NDUT; c++) model_step(c);
    next_cycle();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      apply_stimulus(st($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                        int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                        $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0));
      #4;
      for (int c = 0; c < NDUT; c++) model_check(c, cyc);
      for (int c = 0; c < NDUT; c++) model_step(c);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Parametrised hazard-detection, forwarding and flush controller for the 5-stage pipelined MIPS_Processor (IF/ID/EX/MEM/WB). It tracks in-flight destination registers in a small scoreboard and stalls on load-use or missing-forward hazards. It registers per-operand forwarding selects for the instruction entering EX, and generates pipeline-register flushes when a branch, jump or jr redirect resolves. It replaces the always-enabled, never-flushed PLRegister controls of the first pipelined core.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width.
- FWD_EN, 1, 1 = EX/MEM and MEM/WB forwarding; 0 = no forwarding, stall until producer retires.
- RF_BYPASS, 1, 1 = register file is write-before-read, so WB-stage producers never cause a hazard.
- REDIRECT_STAGE, 2, stage in which redirects resolve: 1 = EX, 2 = MEM.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk, in, 1, core clock.
- reset, in, 1, one clock; reset is synchronous and active-high.
- id_valid, in, 1, the ID stage holds a real instruction.
- id_rs / id_rt, in, REG_ADDR_W, source indices of the ID instruction.
- id_uses_rs / id_uses_rt, in, 1, the source is actually read.
- id_dest, in, REG_ADDR_W, destination after the RegDst / jal mux.
- id_reg_write, in, 1, the ID instruction writes a register.
- id_mem_read, in, 1, the ID instruction is a load.
- redirect, in, 1, a taken branch, jump or jr resolves this cycle in REDIRECT_STAGE.
- pc_en, out, 1, PC register enable.
- if_id_en, out, 1, IF/ID enable.
- if_id_flush, id_ex_flush, ex_mem_flush, out, 1 each, synchronous clear of that pipeline register on the next edge.
- fwd_a_sel / fwd_b_sel, out, 2, ALU operand source for the EX instruction: 00 = ID/EX, 01 = EX/MEM ALU result, 10 = MEM/WB writeback value.
- stall_cnt / flush_cnt, out, CNT_W, saturating statistics counters.

## Operation
- Scoreboard: 3 entries, EX, MEM and WB, each holding {valid, dest, reg_write, is_load}. The scoreboard shifts every cycle: EX→MEM→WB, and WB drops.
- Issue: the EX entry loads the ID instruction when id_valid & !stall & !redirect. Otherwise it loads a bubble (valid = 0).
- Hazard match: entry valid & reg_write & dest != 0 & dest == source & uses_source. Register 0 never matches.
- Stall, FWD_EN = 1: an EX entry is_load that matches either source.
- Stall, FWD_EN = 0: any matching entry in EX or MEM. The WB entry also counts when RF_BYPASS = 0.
- Stall with FWD_EN = 1 and RF_BYPASS = 0: the WB entry additionally counts as a match.
- Stall outputs: pc_en = 0, if_id_en = 0 and a bubble is inserted into ID/EX (id_ex_flush = 1). Older stages keep advancing.
- Forward selects are computed at issue time and registered, so they are valid while the instruction is in EX.
  - Match against the current EX entry (which will be in MEM next cycle) → 01.
  - Otherwise, match against the current MEM entry → 10.
  - Otherwise → 00. The younger producer wins.
  - With FWD_EN = 0, both selects are forced to 00.
- Redirect takes priority over stall:
  - if_id_flush = id_ex_flush = 1, plus ex_mem_flush = 1 when REDIRECT_STAGE = 2.
  - The squashed scoreboard entries become invalid on the same edge.
  - pc_en = 1 so the PC loads the target.
  - The stall is suppressed and not counted.
- Counters:
  - stall_cnt increments on each stall cycle.
  - flush_cnt increments on each redirect cycle.
  - Both saturate at all-ones.

## Timing
- Reset: all scoreboard entries invalid and fwd_*_sel = 00. The *_flush outputs are 0, pc_en = if_id_en = 1 and the counters are 0.
- Reset asserted mid-stall or mid-redirect clears state on that edge. No hazard is carried over.
- stall, flush and enable outputs are combinational from the id_* inputs, redirect and the scoreboard, with zero-cycle latency.
- fwd_*_sel has one-cycle latency: it is registered on the issue edge.
- A load-use stall lasts exactly 1 cycle with FWD_EN = 1.
- With FWD_EN = 0 a stall lasts up to 2 cycles, or 3 cycles when RF_BYPASS = 0.
- Redirect together with stall: the flush wins.

## Structure
- hazard_pkg: the forwarding-select constants (FWD_IDEX, FWD_EXMEM, FWD_MEMWB) and the scoreboard entry struct.
- Sub-module hazard_scoreboard: the 3-entry shift register with per-entry squash and match outputs.
- The top level holds the stall/flush logic, the registered forward selects and the counters.

## Test plan
- lw $t0 followed immediately by add $t1,$t0,$t0, FWD_EN = 1:
  - one stall cycle (pc_en = 0), stall_cnt = 1;
  - fwd_a_sel = fwd_b_sel = 10 when the add is in EX.
- add $t0 then sub $t2,$t0,$t1: no stall, fwd_a_sel = 01, fwd_b_sel = 00.
- Two back-to-back writers to $t0, then a reader: fwd_a_sel = 01, the youngest producer wins.
- addi $zero,... then a reader of $zero: no stall, selects 00.
- Same add→sub pair with FWD_EN = 0, RF_BYPASS = 1: 2 stall cycles, selects 00.
- redirect together with a load-use stall, REDIRECT_STAGE = 2:
  - all three flushes = 1 and pc_en = 1;
  - stall_cnt unchanged, flush_cnt += 1;
  - reset the next cycle returns every output to its reset value.
